// File: rtl/muldiv_seq_unit.sv
// Iterative multiply/divide unit with internal HI/LO: shift-add multiply, restoring divide.
// Optional MADD/MADDU accumulate enabled by defining MULDIV_MADD_EN.
module muldiv_seq_unit #(
    parameter  int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

    state_t             r_state, w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [2:0]         r_op;
    logic [WIDTH-1:0]   r_a, r_b, r_hi, r_lo;
    logic [2*WIDTH-1:0] r_acc;
    logic               r_neg_res, r_neg_rem, r_dz, r_done, r_div_zero;

    logic               w_accept, w_arith, w_is_div_op, w_a_neg, w_b_neg;
    logic [WIDTH-1:0]   w_a_mag, w_b_mag;

    assign w_accept    = (r_state == S_IDLE) && start;
    assign w_is_div_op = (op[2:1] == 2'b01);
`ifdef MULDIV_MADD_EN
    assign w_arith     = !op[2] || (op[2:1] == 2'b11);
`else
    assign w_arith     = !op[2];
`endif
    // op[0] marks the signed variant of every arithmetic op
    assign w_a_neg = op[0] && opa[WIDTH-1];
    assign w_b_neg = op[0] && opb[WIDTH-1];
    assign w_a_mag = w_a_neg ? -opa : opa;
    assign w_b_mag = w_b_neg ? -opb : opb;

    // Multiply step: conditional add into the upper half, then shift right
    logic [WIDTH:0]     w_mul_sum;
    logic [2*WIDTH-1:0] w_mul_step;
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_a} : '0);
    assign w_mul_step = {w_mul_sum, r_acc[WIDTH-1:1]};

    // Divide step: upper half is the partial remainder, lower half shifts dividend out / quotient in
    logic [WIDTH:0]     w_div_sh, w_div_diff;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_step;
    assign w_div_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_div_ge   = (w_div_sh >= {1'b0, r_b});
    assign w_div_diff = w_div_sh - {1'b0, r_b};
    assign w_div_step = {(w_div_ge ? w_div_diff[WIDTH-1:0] : w_div_sh[WIDTH-1:0]),
                         r_acc[WIDTH-2:0], w_div_ge};

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quot, w_rem;
    assign w_prod = r_neg_res ? -r_acc : r_acc;
    assign w_quot = r_neg_res ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_rem  = r_neg_rem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && w_arith) w_next = S_RUN;
            S_RUN:   if (abort) w_next = S_IDLE;
                     else if (r_cnt == CNT_W'(WIDTH - 1)) w_next = S_FIX;
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_op       <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_acc      <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            r_dz       <= 1'b0;
            r_done     <= 1'b0;
            r_div_zero <= 1'b0;
            r_hi       <= '0;
            r_lo       <= '0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    if (op == 3'b100) begin
                        r_hi   <= opa;
                        r_done <= 1'b1;
                    end else if (op == 3'b101) begin
                        r_lo   <= opa;
                        r_done <= 1'b1;
                    end else if (w_arith) begin
                        // Divides keep the raw dividend in r_a for the divide-by-zero result
                        r_op       <= op;
                        r_a        <= w_is_div_op ? opa : w_a_mag;
                        r_b        <= w_b_mag;
                        r_acc      <= {{WIDTH{1'b0}}, (w_is_div_op ? w_a_mag : w_b_mag)};
                        r_neg_res  <= w_a_neg ^ w_b_neg;
                        r_neg_rem  <= w_a_neg;
                        r_dz       <= (opb == '0);
                        r_cnt      <= '0;
                        r_div_zero <= 1'b0;
                    end else begin
                        r_done <= 1'b1;
                    end
                end
                S_RUN: if (!abort) begin
                    r_acc <= (r_op[2:1] == 2'b01) ? w_div_step : w_mul_step;
                    r_cnt <= r_cnt + 1'b1;
                end
                S_FIX: if (!abort) begin
                    r_done <= 1'b1;
                    case (r_op[2:1])
                        2'b00: {r_hi, r_lo} <= w_prod;
                        2'b01: if (r_dz) begin
                            r_hi       <= r_a;
                            r_lo       <= '1;
                            r_div_zero <= 1'b1;
                        end else begin
                            r_hi <= w_rem;
                            r_lo <= w_quot;
                        end
`ifdef MULDIV_MADD_EN
                        2'b11: {r_hi, r_lo} <= {r_hi, r_lo} + w_prod;
`endif
                        default: ;
                    endcase
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE);
    assign done     = r_done;
    assign div_zero = r_div_zero;
    assign hi       = r_hi;
    assign lo       = r_lo;
endmodule
